axi_burst_reader: RTL and testbench

//  AXI4 read master that turns a single (address, beat-count) request from the MMU into
//  one or two INCR bursts on the AR/R channels and streams the returned words back.
//  A burst is split in two when it would cross a 4 KiB boundary.

---
 rtl/axi_burst_reader.sv | 140 ++++++++++++++
 tb/tb_axi_burst_reader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_reader.sv
// rtl/axi_burst_reader.sv - AXI4 read master splitting MMU requests into 4 KiB-safe INCR bursts
//
// Purpose: accepts one (address, beat count) request, issues one INCR burst, or two
// when the request would cross a 4 KiB page, and streams the returned words out.
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   RDEN, RADDR, RLEN        request strobe, byte address, beat count (1..256)
//   BUSY                     request in progress
//   DVALID, DDATA, DLAST     returned word stream; DLAST marks the final word
//   DERR                     with DLAST: some beat returned an error response
//   M_AXI_AR*                AXI read address channel (master side)
//   M_AXI_R*                 AXI read data channel (master side)
module axi_burst_reader #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_OFFSET_WIDTH   = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        RDEN,
  input  logic [C_OFFSET_WIDTH-1:0]   RADDR,
  input  logic [8:0]                  RLEN,
  output logic                        BUSY,
  output logic                        DVALID,
  output logic [C_AXI_DATA_WIDTH-1:0] DDATA,
  output logic                        DLAST,
  output logic                        DERR,
  output logic [C_OFFSET_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                  M_AXI_ARLEN,
  output logic [2:0]                  M_AXI_ARSIZE,
  output logic [1:0]                  M_AXI_ARBURST,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RLAST,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  state_t                      r_state;
  logic [C_OFFSET_WIDTH-1:0]   r_addr;
  logic [8:0]                  r_remaining;
  logic                        r_err;

  logic [9:0]                  w_src_word;
  logic [8:0]                  w_src_rem;
  logic [10:0]                 w_room;
  logic [7:0]                  w_arlen;
  logic [8:0]                  w_beats;
  logic                        w_unused;

  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;

  // The burst length is computed from the incoming request while idle (so ARLEN is
  // ready on the acceptance edge) and from the remaining state for the second half.
  assign w_src_word = (r_state == S_IDLE) ? RADDR[11:2] : r_addr[11:2];
  assign w_src_rem  = (r_state == S_IDLE) ? RLEN : r_remaining;
  // Words left before the next 4 KiB boundary (1..1024).
  assign w_room     = 11'd1024 - {1'b0, w_src_word};
  // When room wins it is below remaining (<=256), so its low 8 bits hold the value;
  // remaining=256 gives 8'h00-1 = 8'hFF, which is the correct ARLEN.
  assign w_arlen    = ({2'b00, w_src_rem} <= w_room) ? (w_src_rem[7:0] - 8'd1)
                                                     : (w_room[7:0] - 8'd1);
  assign w_beats    = {1'b0, M_AXI_ARLEN} + 9'd1;

  // Byte offset within a word and the RRESP OKAY/EXOKAY bit carry no information here.
  assign w_unused   = ^{RADDR[1:0], M_AXI_RRESP[0]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_err         <= 1'b0;
      BUSY          <= 1'b0;
      DVALID        <= 1'b0;
      DDATA         <= '0;
      DLAST         <= 1'b0;
      DERR          <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARLEN   <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      DVALID <= 1'b0;
      DLAST  <= 1'b0;
      DERR   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (RDEN && (RLEN != 9'd0)) begin
            r_addr        <= {RADDR[C_OFFSET_WIDTH-1:2], 2'b00};
            r_remaining   <= RLEN;
            r_err         <= 1'b0;
            BUSY          <= 1'b1;
            M_AXI_ARVALID <= 1'b1;
            M_AXI_ARADDR  <= {RADDR[C_OFFSET_WIDTH-1:2], 2'b00};
            M_AXI_ARLEN   <= w_arlen;
            r_state       <= S_AR;
          end
        end
        S_AR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            r_remaining   <= r_remaining - w_beats;
            r_addr        <= r_addr + {{(C_OFFSET_WIDTH-11){1'b0}}, w_beats, 2'b00};
            M_AXI_RREADY  <= 1'b1;
            r_state       <= S_R;
          end
        end
        S_R: begin
          if (M_AXI_RVALID) begin
            DVALID <= 1'b1;
            DDATA  <= M_AXI_RDATA;
            r_err  <= r_err | M_AXI_RRESP[1];
            if (M_AXI_RLAST) begin
              M_AXI_RREADY <= 1'b0;
              if (r_remaining != 9'd0) begin
                // Second half starts at the page boundary r_addr now points to.
                M_AXI_ARVALID <= 1'b1;
                M_AXI_ARADDR  <= r_addr;
                M_AXI_ARLEN   <= w_arlen;
                r_state       <= S_AR;
              end else begin
                DLAST   <= 1'b1;
                DERR    <= r_err | M_AXI_RRESP[1];
                BUSY    <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_reader.sv
// tb/tb_axi_burst_reader.sv - directed self-checking bench for axi_burst_reader
module tb_axi_burst_reader;

  logic        CLK;
  logic        RST;
  logic        RDEN;
  logic [31:0] RADDR;
  logic [8:0]  RLEN;
  logic        BUSY;
  logic        DVALID;
  logic [31:0] DDATA;
  logic        DLAST;
  logic        DERR;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  axi_burst_reader dut (
    .CLK(CLK), .RST(RST), .RDEN(RDEN), .RADDR(RADDR), .RLEN(RLEN),
    .BUSY(BUSY), .DVALID(DVALID), .DDATA(DDATA), .DLAST(DLAST), .DERR(DERR),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Slave model state; read data is the byte address of the word.
  int          ar_wait  = 0;
  int          err_beat = -1;
  int          ar_count = 0;
  int          s_beat   = 0;
  int          s_left   = 0;
  bit          s_busy   = 0;
  logic [31:0] s_addr   = '0;
  logic [31:0] ar_addrs[$];
  logic [7:0]  ar_lens[$];

  logic [31:0] q_data[$];
  bit          q_last[$];
  bit          q_err[$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // AXI slave: values driven at a negedge are what the next posedge samples.
  initial begin
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b0;
    M_AXI_RLAST   = 1'b0;
    M_AXI_RDATA   = '0;
    M_AXI_RRESP   = 2'b00;
    forever begin
      @(negedge CLK);
      if (RST) begin
        s_busy        = 0;
        M_AXI_RVALID  = 1'b0;
        M_AXI_RLAST   = 1'b0;
        M_AXI_ARREADY = 1'b0;
      end else begin
        if (s_busy) begin
          M_AXI_RVALID = 1'b1;
          M_AXI_RDATA  = s_addr;
          M_AXI_RLAST  = (s_left == 1);
          M_AXI_RRESP  = (s_beat == err_beat) ? 2'b10 : 2'b00;
          if (M_AXI_RREADY) begin
            s_addr = s_addr + 32'd4;
            s_left--;
            s_beat++;
            if (s_left == 0) s_busy = 0;
          end
        end else begin
          M_AXI_RVALID = 1'b0;
          M_AXI_RLAST  = 1'b0;
          M_AXI_RRESP  = 2'b00;
        end
        M_AXI_ARREADY = (ar_wait == 0);
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          ar_addrs.push_back(M_AXI_ARADDR);
          ar_lens.push_back(M_AXI_ARLEN);
          ar_count++;
          s_addr = M_AXI_ARADDR;
          s_left = int'(M_AXI_ARLEN) + 1;
          s_busy = 1;
        end else if (M_AXI_ARVALID && ar_wait > 0) begin
          ar_wait--;
        end
      end
    end
  end

  // Output monitor.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST && DVALID) begin
        q_data.push_back(DDATA);
        q_last.push_back(DLAST);
        q_err.push_back(DERR);
        if (DLAST) check("busy_low_with_dlast", 32'(BUSY), 32'd0);
      end
    end
  end

  task automatic clear();
    q_data.delete();
    q_last.delete();
    q_err.delete();
    ar_addrs.delete();
    ar_lens.delete();
    ar_count = 0;
    s_beat   = 0;
    err_beat = -1;
    ar_wait  = 0;
  endtask

  task automatic do_req(input logic [31:0] addr, input logic [8:0] len);
    @(negedge CLK);
    RDEN  = 1'b1;
    RADDR = addr;
    RLEN  = len;
    @(negedge CLK);
    RDEN  = 1'b0;
    #1;
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge CLK);
      #1;
      if (!BUSY) break;
    end
    if (i == 3000) check({tag, "_timeout"}, 32'd1, 32'd0);
    repeat (2) @(negedge CLK);
    #1;
  endtask

  task automatic verify(input string tag, input logic [31:0] start, input int len,
                        input bit exp_err);
    check({tag, "_nbeats"}, 32'(q_data.size()), 32'(len));
    for (int i = 0; i < len && i < q_data.size(); i++) begin
      check({tag, "_data"}, q_data[i], start + 32'(4 * i));
      check({tag, "_last"}, 32'(q_last[i]), 32'(i == len - 1));
      check({tag, "_err"}, 32'(q_err[i]), (i == len - 1) ? 32'(exp_err) : 32'd0);
    end
  endtask

  task automatic check_ar(input string tag, input int idx, input logic [31:0] addr,
                          input logic [7:0] len);
    if (idx < ar_addrs.size()) begin
      check({tag, "_araddr"}, ar_addrs[idx], addr);
      check({tag, "_arlen"}, 32'(ar_lens[idx]), 32'(len));
    end else begin
      check({tag, "_ar_missing"}, 32'(ar_addrs.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    RST   = 1'b1;
    RDEN  = 1'b0;
    RADDR = '0;
    RLEN  = '0;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_dvalid", 32'(DVALID), 32'd0);
    check("rst_dlast", 32'(DLAST), 32'd0);
    check("rst_derr", 32'(DERR), 32'd0);
    check("rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
    check("rst_rready", 32'(M_AXI_RREADY), 32'd0);
    check("rst_ddata", DDATA, 32'd0);
    check("rst_araddr", M_AXI_ARADDR, 32'd0);
    check("rst_arlen", 32'(M_AXI_ARLEN), 32'd0);
    check("arsize", 32'(M_AXI_ARSIZE), 32'd2);
    check("arburst", 32'(M_AXI_ARBURST), 32'd1);
    RST = 1'b0;

    // 1: single aligned burst.
    clear();
    do_req(32'h0000_1000, 9'd8);
    check("t1_busy", 32'(BUSY), 32'd1);
    wait_done("t1");
    check("t1_arcount", 32'(ar_count), 32'd1);
    check_ar("t1", 0, 32'h0000_1000, 8'd7);
    verify("t1", 32'h0000_1000, 8, 1'b0);
    check("t1_busy_after", 32'(BUSY), 32'd0);

    // 2: split at 4 KiB boundary.
    clear();
    do_req(32'h0000_0FF8, 9'd4);
    wait_done("t2");
    check("t2_arcount", 32'(ar_count), 32'd2);
    check_ar("t2a", 0, 32'h0000_0FF8, 8'd1);
    check_ar("t2b", 1, 32'h0000_1000, 8'd1);
    verify("t2", 32'h0000_0FF8, 4, 1'b0);

    // 3: ARREADY withheld for 5 cycles; low address bits ignored.
    clear();
    ar_wait = 5;
    do_req(32'h0000_6003, 9'd4);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge CLK);
        #1;
      end
      check("t3_arvalid_held", 32'(M_AXI_ARVALID), 32'd1);
      check("t3_araddr_held", M_AXI_ARADDR, 32'h0000_6000);
      check("t3_arlen_held", 32'(M_AXI_ARLEN), 32'd3);
      check("t3_rready_wait", 32'(M_AXI_RREADY), 32'd0);
    end
    wait_done("t3");
    check("t3_arcount", 32'(ar_count), 32'd1);
    verify("t3", 32'h0000_6000, 4, 1'b0);

    // 4: error response on beat 3, then a clean request.
    clear();
    err_beat = 2;
    do_req(32'h0000_7000, 9'd4);
    wait_done("t4");
    verify("t4", 32'h0000_7000, 4, 1'b1);
    clear();
    do_req(32'h0000_7100, 9'd3);
    wait_done("t4c");
    verify("t4c", 32'h0000_7100, 3, 1'b0);

    // 5: RDEN while busy is ignored; RLEN=0 is dropped.
    clear();
    do_req(32'h0000_4000, 9'd8);
    @(negedge CLK);
    RDEN  = 1'b1;
    RADDR = 32'h0000_5000;
    RLEN  = 9'd3;
    @(negedge CLK);
    RDEN  = 1'b0;
    wait_done("t5");
    check("t5_arcount", 32'(ar_count), 32'd1);
    check_ar("t5", 0, 32'h0000_4000, 8'd7);
    verify("t5", 32'h0000_4000, 8, 1'b0);
    clear();
    do_req(32'h0000_8000, 9'd0);
    check("t5z_busy", 32'(BUSY), 32'd0);
    repeat (5) @(negedge CLK);
    #1;
    check("t5z_arvalid", 32'(M_AXI_ARVALID), 32'd0);
    check("t5z_arcount", 32'(ar_count), 32'd0);
    check("t5z_beats", 32'(q_data.size()), 32'd0);

    // 256 beats: aligned stays one burst, offset start splits 64 + 192.
    clear();
    do_req(32'h0001_0000, 9'd256);
    wait_done("t7");
    check("t7_arcount", 32'(ar_count), 32'd1);
    check_ar("t7", 0, 32'h0001_0000, 8'd255);
    verify("t7", 32'h0001_0000, 256, 1'b0);
    clear();
    do_req(32'h0000_1F00, 9'd256);
    wait_done("t8");
    check("t8_arcount", 32'(ar_count), 32'd2);
    check_ar("t8a", 0, 32'h0000_1F00, 8'd63);
    check_ar("t8b", 1, 32'h0000_2000, 8'd191);
    verify("t8", 32'h0000_1F00, 256, 1'b0);

    // 6: reset during beat 2 of 8.
    clear();
    do_req(32'h0000_2000, 9'd8);
    for (int i = 0; i < 50; i++) begin
      if (q_data.size() >= 1) break;
      @(negedge CLK);
      #1;
    end
    check("t6_got_beat1", 32'(q_data.size() >= 1), 32'd1);
    RST = 1'b1;
    #1;
    check("t6_rst_busy", 32'(BUSY), 32'd0);
    check("t6_rst_dvalid", 32'(DVALID), 32'd0);
    check("t6_rst_dlast", 32'(DLAST), 32'd0);
    check("t6_rst_derr", 32'(DERR), 32'd0);
    check("t6_rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
    check("t6_rst_rready", 32'(M_AXI_RREADY), 32'd0);
    check("t6_rst_ddata", DDATA, 32'd0);
    check("t6_rst_araddr", M_AXI_ARADDR, 32'd0);
    check("t6_rst_arlen", 32'(M_AXI_ARLEN), 32'd0);
    repeat (2) @(negedge CLK);
    #1;
    RST = 1'b0;
    clear();
    do_req(32'h0000_3000, 9'd2);
    wait_done("t6");
    check("t6_arcount", 32'(ar_count), 32'd1);
    check_ar("t6", 0, 32'h0000_3000, 8'd1);
    verify("t6", 32'h0000_3000, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
